spi_reg_primary: RTL and testbench
==================================

SPI_REG_PRIMARY -- requirements
Module: spi_reg_primary

Interface
REQ-001 SHALL have parameter CLK_DIV, default 1; clk cycles per sclk half-period; legal range 1..255.
REQ-002 SHALL have port clk  input  1  system clock; all logic on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port start  input  1  one-cycle transaction request; sampled only in IDLE.
REQ-005 SHALL have port rw  input  1  0 = WRITE, 1 = READ; captured with start.
REQ-006 SHALL have port addr  input  8  register address; captured with start.
REQ-007 SHALL have port wdata  input  8  write data; captured with start.
REQ-008 SHALL have port burst_len  input  4  read byte count minus 1; captured with start.
REQ-009 SHALL have port busy  output  1  high from the cycle after start acceptance until done.
REQ-010 SHALL have port done  output  1  one-cycle pulse at transaction end.
REQ-011 SHALL have port rdata  output  8  last received read byte; held until the next byte.
REQ-012 SHALL have port rdata_valid  output  1  one-cycle pulse per received read byte.
REQ-013 SHALL have ports sclk (output, 1), mosi (output, 1), miso (input, 1), cs (output, 1, active-low): the SPI bus.

Function
REQ-014 SHALL implement SPI mode 0: sclk idles low; secondary samples mosi on sclk rise; mosi changes only on sclk fall or at cs fall; miso sampled on the clk edge that drives sclk high.
REQ-015 SHALL use states IDLE -> CS_SETUP -> SHIFT -> CS_HOLD -> IDLE.
REQ-016 SHALL, on start in IDLE, next cycle drive cs=0, busy=1, mosi=cmd bit7, and enter CS_SETUP for CLK_DIV cycles.
REQ-017 SHALL send MSB first, one bit per sclk period of 2*CLK_DIV cycles, with no sclk gap between bytes.
REQ-018 SHALL, for WRITE, send exactly 0x0A, addr, wdata (24 sclk rises), then CS_HOLD.
REQ-019 SHALL, for READ, send 0x0B, addr, then clock burst_len+1 bytes with mosi=0, then CS_HOLD.
REQ-020 SHALL, for each read byte, update rdata and pulse rdata_valid the cycle after its 8th sclk rise.
REQ-021 SHALL, in CS_HOLD, drive cs=1, sclk=0 for 2*CLK_DIV cycles, then pulse done with busy falling in the same cycle.
REQ-022 SHALL ignore start while busy; no capture, no queueing.
REQ-023 SHALL treat burst_len=0 as one read byte and burst_len=15 as sixteen.
REQ-024 SHALL count bits with a 3-bit counter wrapping 7->0 at each byte boundary.

Reset
REQ-025 SHALL, with rst high at a clk edge, force IDLE, cs=1, sclk=0, mosi=0, busy=0, done=0, rdata=0x00, rdata_valid=0.
REQ-026 SHALL, with rst asserted mid-transfer, abandon the transfer with no done pulse and no partial rdata_valid.
REQ-027 SHALL give rst priority over start in the same cycle.

Configuration
REQ-028 SHALL, with macro SPI_PRIMARY_ABORT_EN defined, have port abort (input, 1): during SHIFT, finish the current byte, skip the remaining bytes, then enter CS_HOLD and pulse done normally.
REQ-029 SHALL, without SPI_PRIMARY_ABORT_EN, have no abort port; every transaction runs to full length.

Structure
REQ-030 SHALL take WRITE_CMD=8'h0A, READ_CMD=8'h0B and the state encoding from shared package spi_pkg.
REQ-031 SHALL place the 8-bit shift register and bit counter in sub-module spi_shift_byte, instantiated once.

Verification
REQ-032 SHALL cover WRITE, CLK_DIV=1, addr=0x2D, wdata=0x02 -> mosi sequence 0x0A,0x2D,0x02 on 24 sclk rises; cs low throughout; one done pulse.
REQ-033 SHALL cover READ, addr=0x0E, burst_len=2, miso model returning 0xA5,0x3C,0xFF -> three rdata_valid pulses with those values; 40 sclk rises.
REQ-034 SHALL cover start repeated every cycle while busy -> exactly one transaction and one done.
REQ-035 SHALL cover rst after 10 sclk rises of a WRITE -> cs=1 and sclk=0 the next cycle, no done; a following WRITE is correct.
REQ-036 SHALL cover CLK_DIV=3, WRITE -> sclk high and low for 3 clk cycles each; mosi stable across every sclk rise.
REQ-037 SHALL cover, with SPI_PRIMARY_ABORT_EN, abort during byte 2 of a READ with burst_len=7 -> exactly 2 rdata_valid pulses, then cs high and done.

Source files
------------

// File: rtl/spi_pkg.sv
// Shared command bytes, FSM encoding and byte-sequencing helper for the SPI register primary.
package spi_pkg;

  localparam logic [7:0] WRITE_CMD = 8'h0A;
  localparam logic [7:0] READ_CMD  = 8'h0B;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_CS_SETUP = 2'd1,
    ST_SHIFT    = 2'd2,
    ST_CS_HOLD  = 2'd3
  } spi_state_e;

  // Byte sent at position idx (idx >= 1); read payload bytes clock out zeros.
  function automatic logic [7:0] tx_byte(input logic [4:0] idx, input logic rw,
                                         input logic [7:0] addr, input logic [7:0] wdata);
    logic [7:0] b;
    b = 8'h00;
    if (idx == 5'd1) b = addr;
    else if (idx == 5'd2 && !rw) b = wdata;
    return b;
  endfunction

endpackage

// File: rtl/spi_shift_byte.sv
// 8-bit MSB-first shift register with a 3-bit bit counter that wraps 7->0 at byte boundaries.
module spi_shift_byte (
  input  logic       clk,
  input  logic       rst,
  input  logic       clear,
  input  logic       load,
  input  logic       shift,
  input  logic [7:0] load_data,
  input  logic       miso,
  output logic       tx_bit,
  output logic [7:0] rx_byte,
  output logic       byte_end
);

  logic [7:0] sr_q, sr_d;
  logic [2:0] bit_q, bit_d;

  always_comb begin
    bit_d = bit_q;
    sr_d  = sr_q;
    if (clear) bit_d = 3'd0;
    else if (shift) bit_d = bit_q + 3'd1;
    // A load at the byte boundary replaces the shift so the next byte is ready for the fall.
    if (load) sr_d = load_data;
    else if (shift) sr_d = {sr_q[6:0], miso};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sr_q  <= 8'h00;
      bit_q <= 3'd0;
    end else begin
      sr_q  <= sr_d;
      bit_q <= bit_d;
    end
  end

  assign tx_bit   = sr_q[7];
  assign rx_byte  = {sr_q[6:0], miso};
  assign byte_end = (bit_q == 3'd7);

endmodule

// File: rtl/spi_reg_primary.sv
// SPI mode-0 register-access primary: WRITE (0x0A, addr, wdata) and burst READ (0x0B, addr, N bytes).
// Optional abort input is enabled by defining SPI_PRIMARY_ABORT_EN.
module spi_reg_primary
  import spi_pkg::*;
#(
  parameter int CLK_DIV = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       rw,
  input  logic [7:0] addr,
  input  logic [7:0] wdata,
  input  logic [3:0] burst_len,
`ifdef SPI_PRIMARY_ABORT_EN
  input  logic       abort,
`endif
  output logic       busy,
  output logic       done,
  output logic [7:0] rdata,
  output logic       rdata_valid,
  output logic       sclk,
  output logic       mosi,
  input  logic       miso,
  output logic       cs,
  output logic [1:0] state_dbg
);

  spi_state_e state_q, state_d;
  logic [8:0] div_q, div_d;
  logic [4:0] byte_q, byte_d, last_q, last_d;
  logic       rw_q, rw_d, fin_q, fin_d, abort_q, abort_d;
  logic [7:0] addr_q, addr_d, wdata_q, wdata_d, rdata_q, rdata_d;
  logic       sclk_q, sclk_d, mosi_q, mosi_d, cs_q, cs_d;
  logic       busy_q, busy_d, done_q, done_d, rdata_valid_q, rdata_valid_d;

  logic       sr_clear, sr_load, sr_shift, do_rise, abort_in, abort_now;
  logic [7:0] sr_load_data, rx_byte;
  logic       tx_bit, byte_end, half_end, hold_end;

`ifdef SPI_PRIMARY_ABORT_EN
  assign abort_in = abort;
`else
  assign abort_in = 1'b0;
`endif

  assign half_end  = (div_q == 9'(CLK_DIV - 1));
  assign hold_end  = (div_q == 9'(2 * CLK_DIV - 1));
  assign abort_now = abort_q | (abort_in && state_q == ST_SHIFT);

  spi_shift_byte u_shift (
    .clk      (clk),
    .rst      (rst),
    .clear    (sr_clear),
    .load     (sr_load),
    .shift    (sr_shift),
    .load_data(sr_load_data),
    .miso     (miso),
    .tx_bit   (tx_bit),
    .rx_byte  (rx_byte),
    .byte_end (byte_end)
  );

  always_comb begin
    state_d = state_q;  div_d = div_q;  byte_d = byte_q;  last_d = last_q;
    rw_d = rw_q;  addr_d = addr_q;  wdata_d = wdata_q;  fin_d = fin_q;  abort_d = abort_q;
    sclk_d = sclk_q;  mosi_d = mosi_q;  cs_d = cs_q;  busy_d = busy_q;  done_d = 1'b0;
    rdata_d = rdata_q;  rdata_valid_d = 1'b0;
    sr_clear = 1'b0;  sr_load = 1'b0;  sr_shift = 1'b0;  sr_load_data = 8'h00;  do_rise = 1'b0;
    case (state_q)
      ST_IDLE: if (start) begin
        rw_d = rw;  addr_d = addr;  wdata_d = wdata;
        last_d = rw ? 5'(burst_len) + 5'd2 : 5'd2;
        sr_clear = 1'b1;  sr_load = 1'b1;
        sr_load_data = rw ? READ_CMD : WRITE_CMD;
        mosi_d = sr_load_data[7];
        cs_d = 1'b0;  busy_d = 1'b1;  div_d = 9'd0;  byte_d = 5'd0;
        fin_d = 1'b0;  abort_d = 1'b0;
        state_d = ST_CS_SETUP;
      end
      ST_CS_SETUP: if (half_end) begin
        div_d = 9'd0;  do_rise = 1'b1;  state_d = ST_SHIFT;
      end else div_d = div_q + 9'd1;
      ST_SHIFT: begin
        abort_d = abort_now;
        if (half_end) begin
          div_d = 9'd0;
          if (sclk_q) begin
            sclk_d = 1'b0;
            if (fin_q) begin
              state_d = ST_CS_HOLD;  cs_d = 1'b1;  mosi_d = 1'b0;
            end else mosi_d = tx_bit;
          end else do_rise = 1'b1;
        end else div_d = div_q + 9'd1;
      end
      ST_CS_HOLD: if (hold_end) begin
        div_d = 9'd0;  state_d = ST_IDLE;  busy_d = 1'b0;  done_d = 1'b1;
      end else div_d = div_q + 9'd1;
      default: state_d = ST_IDLE;
    endcase
    // Rising sclk edge: sample miso; at the 8th bit either queue the next byte or finish.
    if (do_rise) begin
      sclk_d = 1'b1;  sr_shift = 1'b1;
      if (byte_end) begin
        if (rw_q && byte_q >= 5'd2) begin
          rdata_d = rx_byte;  rdata_valid_d = 1'b1;
        end
        if (byte_q == last_q || abort_now) fin_d = 1'b1;
        else begin
          byte_d = byte_q + 5'd1;  sr_load = 1'b1;
          sr_load_data = tx_byte(byte_q + 5'd1, rw_q, addr_q, wdata_q);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;  div_q <= 9'd0;  byte_q <= 5'd0;  last_q <= 5'd0;
      rw_q <= 1'b0;  addr_q <= 8'h00;  wdata_q <= 8'h00;  fin_q <= 1'b0;  abort_q <= 1'b0;
      sclk_q <= 1'b0;  mosi_q <= 1'b0;  cs_q <= 1'b1;  busy_q <= 1'b0;  done_q <= 1'b0;
      rdata_q <= 8'h00;  rdata_valid_q <= 1'b0;
    end else begin
      state_q <= state_d;  div_q <= div_d;  byte_q <= byte_d;  last_q <= last_d;
      rw_q <= rw_d;  addr_q <= addr_d;  wdata_q <= wdata_d;  fin_q <= fin_d;  abort_q <= abort_d;
      sclk_q <= sclk_d;  mosi_q <= mosi_d;  cs_q <= cs_d;  busy_q <= busy_d;  done_q <= done_d;
      rdata_q <= rdata_d;  rdata_valid_q <= rdata_valid_d;
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign rdata       = rdata_q;
  assign rdata_valid = rdata_valid_q;
  assign sclk        = sclk_q;
  assign mosi        = mosi_q;
  assign cs          = cs_q;
  assign state_dbg   = state_q;

endmodule

// File: tb/tb_spi_reg_primary.sv
// Bench for spi_reg_primary: CLK_DIV=1 and CLK_DIV=3 instances, vector table plus corner sequences.
`timescale 1ns/1ps
module tb_spi_reg_primary;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, start1, start3, rw, miso;
  logic [7:0] addr, wdata;
  logic [3:0] burst_len;
`ifdef SPI_PRIMARY_ABORT_EN
  logic       abort;
`endif
  logic       busy1, done1, rv1, sclk1, mosi1, cs1;
  logic       busy3, done3, rv3, sclk3, mosi3, cs3;
  logic [7:0] rdata1, rdata3;
  logic [1:0] st1, st3;

  spi_reg_primary #(.CLK_DIV(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .rw(rw), .addr(addr), .wdata(wdata),
    .burst_len(burst_len),
`ifdef SPI_PRIMARY_ABORT_EN
    .abort(abort),
`endif
    .busy(busy1), .done(done1), .rdata(rdata1), .rdata_valid(rv1), .sclk(sclk1),
    .mosi(mosi1), .miso(miso), .cs(cs1), .state_dbg(st1)
  );

  spi_reg_primary #(.CLK_DIV(3)) dut3 (
    .clk(clk), .rst(rst), .start(start3), .rw(rw), .addr(addr), .wdata(wdata),
    .burst_len(burst_len),
`ifdef SPI_PRIMARY_ABORT_EN
    .abort(abort),
`endif
    .busy(busy3), .done(done3), .rdata(rdata3), .rdata_valid(rv3), .sclk(sclk3),
    .mosi(mosi3), .miso(miso), .cs(cs3), .state_dbg(st3)
  );

  // Observed instance selected by its divider
  int cur_sel = 1;
  logic s_busy, s_done, s_rv, s_sclk, s_mosi, s_cs;
  logic [7:0] s_rdata;
  assign s_busy  = (cur_sel == 3) ? busy3  : busy1;
  assign s_done  = (cur_sel == 3) ? done3  : done1;
  assign s_rv    = (cur_sel == 3) ? rv3    : rv1;
  assign s_sclk  = (cur_sel == 3) ? sclk3  : sclk1;
  assign s_mosi  = (cur_sel == 3) ? mosi3  : mosi1;
  assign s_cs    = (cur_sel == 3) ? cs3    : cs1;
  assign s_rdata = (cur_sel == 3) ? rdata3 : rdata1;

  int checks = 0;
  int failures = 0;
  logic [7:0] exp_q[$];

  int rises, dones, cs_err, mosi_err, tim_err, db_err, setup_cnt, hold_cnt, ones_after, rv_extra;
  logic [23:0]  mosi_word;
  logic [127:0] rx_word;

  typedef struct {
    string        name;
    int           div;
    logic         rw;
    logic [7:0]   addr;
    logic [7:0]   wdata;
    logic [3:0]   blen;
    logic [127:0] rx;
    int           n_rx;
    int           exp_rises;
    logic [23:0]  exp_word;
  } vec_t;
  vec_t vecs[6];

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
    end
  endtask

  // mode: 0 normal, 1 start held every cycle while busy, 2 reset after 10 rises, 3 abort mid byte 3
  task automatic run_txn(input int div, input logic rw_i, input logic [7:0] a, input logic [7:0] w,
                         input logic [3:0] bl, input logic [127:0] rx, input int n_rx,
                         input int mode);
    logic prev_sclk, prev_mosi, rst_hit, ab_hit;
    int run_len, tail, idx;
    cur_sel = div;  rx_word = rx;
    rises = 0;  dones = 0;  cs_err = 0;  mosi_err = 0;  tim_err = 0;  db_err = 0;
    setup_cnt = 0;  hold_cnt = 0;  ones_after = 0;  rv_extra = 0;  mosi_word = 24'h0;
    exp_q.delete();
    for (int k = 0; k < n_rx; k++) exp_q.push_back(rx[8*k +: 8]);
    @(negedge clk);
    rw = rw_i;  addr = a;  wdata = w;  burst_len = bl;  miso = 1'b0;
    if (div == 3) start3 = 1'b1; else start1 = 1'b1;
    prev_sclk = s_sclk;  prev_mosi = s_mosi;  run_len = 0;  tail = -1;
    rst_hit = 1'b0;  ab_hit = 1'b0;
    for (int cyc = 0; cyc < 4000 && tail != 0; cyc++) begin
      @(negedge clk);
      if (s_sclk != prev_sclk) begin
        if (prev_sclk && run_len != div) tim_err++;
        if (!prev_sclk && rises > 0 && run_len != div) tim_err++;
        run_len = 1;
      end else run_len++;
      if (s_sclk && !prev_sclk) begin
        rises++;
        if (s_cs) cs_err++;
        if (s_mosi != prev_mosi) mosi_err++;
        if (rises <= 24) mosi_word = {mosi_word[22:0], s_mosi};
        else if (s_mosi) ones_after++;
      end
      if (s_busy && !s_cs && rises == 0 && !s_sclk) setup_cnt++;
      if (s_busy && s_cs) hold_cnt++;
      if (s_rv) begin
        if (exp_q.size() == 0) rv_extra++;
        else check("rdata", {24'h0, s_rdata}, {24'h0, exp_q.pop_front()});
      end
      if (s_done) begin
        dones++;
        if (s_busy) db_err++;
        if (tail < 0) tail = (mode == 1) ? 60 : 20;
      end
      if (tail > 0) tail--;
      if (mode == 1 && dones == 0) begin
        if (div == 3) start3 = 1'b1; else start1 = 1'b1;
        addr = ~addr;  wdata = ~wdata;  rw = ~rw;
      end else begin
        start1 = 1'b0;  start3 = 1'b0;
      end
`ifdef SPI_PRIMARY_ABORT_EN
      abort = (mode == 3 && rises == 27 && !ab_hit);
      if (abort) ab_hit = 1'b1;
`endif
      if (mode == 2 && rises == 10 && !rst_hit) begin
        rst_hit = 1'b1;
        rst = 1'b1;
        @(negedge clk);
        check("rst_mid_cs", s_cs, 1);
        check("rst_mid_sclk", s_sclk, 0);
        check("rst_mid_busy", s_busy, 0);
        check("rst_mid_rv", s_rv, 0);
        check("rst_mid_rdata", s_rdata, 0);
        rst = 1'b0;
        tail = 40;
      end
      if (!s_sclk) begin
        if (rises >= 16 && rises - 16 < 128) begin
          idx = 8 * ((rises - 16) / 8) + 7 - ((rises - 16) % 8);
          miso = rx_word[idx];
        end else miso = 1'b0;
      end
      prev_sclk = s_sclk;  prev_mosi = s_mosi;
    end
    start1 = 1'b0;  start3 = 1'b0;  miso = 1'b0;
  endtask

  task automatic check_txn(input string nm, input int div, input int exp_rises,
                           input logic [23:0] exp_word);
    check({nm, "_done"}, dones, 1);
    check({nm, "_rises"}, rises, exp_rises);
    check({nm, "_mosi"}, {8'h0, mosi_word}, {8'h0, exp_word});
    check({nm, "_mosi_tail"}, ones_after, 0);
    check({nm, "_cs_low"}, cs_err, 0);
    check({nm, "_mosi_stable"}, mosi_err, 0);
    check({nm, "_sclk_timing"}, tim_err, 0);
    check({nm, "_done_busy"}, db_err, 0);
    check({nm, "_setup_len"}, setup_cnt, div);
    check({nm, "_hold_len"}, hold_cnt, 2 * div);
    check({nm, "_rd_missing"}, exp_q.size(), 0);
    check({nm, "_rd_extra"}, rv_extra, 0);
    check({nm, "_idle_cs"}, s_cs, 1);
  endtask

  initial begin
    rst = 1'b1;  start1 = 1'b0;  start3 = 1'b0;  rw = 1'b0;  miso = 1'b0;
    addr = 8'h00;  wdata = 8'h00;  burst_len = 4'd0;
`ifdef SPI_PRIMARY_ABORT_EN
    abort = 1'b0;
`endif
    vecs[0] = '{"wr_2d",    1, 1'b0, 8'h2D, 8'h02, 4'd0,  128'h0,      0,  24, 24'h0A2D02};
    vecs[1] = '{"rd_0e",    1, 1'b1, 8'h0E, 8'hEE, 4'd2,  128'hFF3CA5, 3,  40, 24'h0B0E00};
    vecs[2] = '{"wr_div3",  3, 1'b0, 8'hFF, 8'h81, 4'd0,  128'h0,      0,  24, 24'h0AFF81};
    vecs[3] = '{"rd_len0",  1, 1'b1, 8'h80, 8'hEE, 4'd0,  128'h5A,     1,  24, 24'h0B8000};
    vecs[4] = '{"rd_div3",  3, 1'b1, 8'h01, 8'hEE, 4'd1,  128'h3CC3,   2,  32, 24'h0B0100};
    vecs[5] = '{"rd_len15", 1, 1'b1, 8'h7F, 8'hEE, 4'd15,
                128'h0123456789ABCDEFFEDCBA9876543210, 16, 144, 24'h0B7F00};

    repeat (3) @(negedge clk);
    check("rst_cs1", cs1, 1);        check("rst_cs3", cs3, 1);
    check("rst_sclk1", sclk1, 0);    check("rst_sclk3", sclk3, 0);
    check("rst_mosi1", mosi1, 0);    check("rst_busy1", busy1, 0);
    check("rst_done1", done1, 0);    check("rst_rdata1", rdata1, 0);
    check("rst_rv1", rv1, 0);        check("rst_state1", st1, 0);
    check("rst_state3", st3, 0);
    rst = 1'b0;

    for (int i = 0; i < 6; i++) begin
      run_txn(vecs[i].div, vecs[i].rw, vecs[i].addr, vecs[i].wdata, vecs[i].blen,
              vecs[i].rx, vecs[i].n_rx, 0);
      check_txn(vecs[i].name, vecs[i].div, vecs[i].exp_rises, vecs[i].exp_word);
    end

    run_txn(1, 1'b0, 8'h2D, 8'h02, 4'd0, 128'h0, 0, 1);
    check_txn("start_repeat", 1, 24, 24'h0A2D02);

    run_txn(1, 1'b0, 8'h2D, 8'h02, 4'd0, 128'h0, 0, 2);
    check("rst_mid_no_done", dones, 0);
    check("rst_mid_no_rv", rv_extra, 0);
    check("rst_mid_rises", rises, 10);
    run_txn(1, 1'b0, 8'h5C, 8'hA7, 4'd0, 128'h0, 0, 0);
    check_txn("wr_after_rst", 1, 24, 24'h0A5CA7);

    @(negedge clk);
    rst = 1'b1;  start1 = 1'b1;  rw = 1'b0;
    @(negedge clk);
    check("rst_prio_busy", busy1, 0);
    check("rst_prio_cs", cs1, 1);
    check("rst_prio_state", st1, 0);
    rst = 1'b0;  start1 = 1'b0;
    @(negedge clk);
    check("rst_prio_idle", busy1, 0);

`ifdef SPI_PRIMARY_ABORT_EN
    run_txn(1, 1'b1, 8'h33, 8'h00, 4'd7, 128'h8877665544332211, 2, 3);
    check_txn("abort_rd", 1, 32, 24'h0B3300);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
